// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter driving the single write port of the 16-entry register file.
// Latency: request sampled at edge k, registered write visible for the cycle after edge k.
// Backpressure: stall=1 withholds grants; losers and stalled requesters hold req until gnt.
//
// Ports:
//    clk       rising-edge clock
//    reset     asynchronous, active-low; clears every register immediately
//    stall     1 = issue no grant at this edge (pointer frozen)
//    req       per-requester write request
//    req_addr  requester i address at [i*ADDR_W +: ADDR_W]
//    req_data  requester i data at [i*DATA_W +: DATA_W]
//    gnt       registered one-hot grant pulse
//    wr_en     registered write enable / decoder enable (always equals |gnt)
//    wr_sel    registered decoder select (register address)
//    wr_data   registered write data
module regfile_write_arbiter #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       stall,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*ADDR_W-1:0]    req_addr,
   input  logic [N_REQ*DATA_W-1:0]    req_data,
   output logic [N_REQ-1:0]           gnt,
   output logic                       wr_en,
   output logic [ADDR_W-1:0]          wr_sel,
   output logic [DATA_W-1:0]          wr_data
);

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   // Registered state
   logic [PTR_W-1:0]  ptr_q,     ptr_d;
   logic [N_REQ-1:0]  gnt_q,     gnt_d;
   logic              wr_en_q,   wr_en_d;
   logic [ADDR_W-1:0] wr_sel_q,  wr_sel_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   // Arbitration results
   logic [N_REQ-1:0]  elig;
   logic              win_vld;
   logic [PTR_W-1:0]  win_idx;
   logic [PTR_W:0]    cand;

   // Per-requester views of the flattened address/data buses
   logic [ADDR_W-1:0] addr_arr [N_REQ];
   logic [DATA_W-1:0] data_arr [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
      assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
   end

   // The requester currently holding gnt is masked so that a req still high
   // in the cycle it observes its grant does not produce a duplicate write.
   assign elig = req & ~gnt_q & {N_REQ{~stall}};

   // Rotating priority search: candidates ptr, ptr+1, ... wrapping mod N_REQ.
   // cand carries one extra bit so the sum can exceed N_REQ-1 before wrapping.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
         if (cand >= (PTR_W+1)'(N_REQ)) begin
            cand = cand - (PTR_W+1)'(N_REQ);
         end
         if (!win_vld && elig[cand[PTR_W-1:0]]) begin
            win_vld = 1'b1;
            win_idx = cand[PTR_W-1:0];
         end
      end
   end

   // Next-state: a winner loads the write port and moves priority past itself;
   // no winner clears the pulse but leaves select/data untouched.
   always_comb begin
      ptr_d     = ptr_q;
      gnt_d     = '0;
      wr_en_d   = 1'b0;
      wr_sel_d  = wr_sel_q;
      wr_data_d = wr_data_q;
      if (win_vld) begin
         gnt_d[win_idx] = 1'b1;
         wr_en_d        = 1'b1;
         wr_sel_d       = addr_arr[win_idx];
         wr_data_d      = data_arr[win_idx];
         if (win_idx == PTR_W'(N_REQ - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = win_idx + PTR_W'(1);
         end
      end
   end

   // Reset drops any in-flight write immediately; the granted requester
   // may not have seen its pulse and will simply re-arbitrate.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q     <= '0;
         gnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_sel_q  <= '0;
         wr_data_q <= '0;
      end else begin
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         wr_en_q   <= wr_en_d;
         wr_sel_q  <= wr_sel_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign gnt     = gnt_q;
   assign wr_en   = wr_en_q;
   assign wr_sel  = wr_sel_q;
   assign wr_data = wr_data_q;

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Round-robin write-port arbiter for the 16-entry register file. Up to N_REQ requesters each present a 4-bit register address and a data word; the block grants one per cycle and drives the register file's single write port: the enabled 4-to-16 write decoder's select and enable, plus the write data. All outputs are registered, so the decoder and register file see a clean, glitch-free write one cycle after arbitration.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 64, register data width
- ADDR_W, 4, register address width (fixed 4 for the 16-entry file)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately
- stall  input  1  1 = issue no grant this cycle
- req  input  N_REQ  per-requester write request
- req_addr  input  N_REQ*ADDR_W  requester i address at [i*ADDR_W +: ADDR_W]
- req_data  input  N_REQ*DATA_W  requester i data at [i*DATA_W +: DATA_W]
- gnt  output  N_REQ  one-hot grant pulse, registered
- wr_en  output  1  decoder enable / register file write enable, registered
- wr_sel  output  ADDR_W  decoder select (bit 3 = sel3 … bit 0 = sel0), registered
- wr_data  output  DATA_W  write data, registered

## Operation
- State: priority pointer ptr, width clog2(N_REQ), plus output registers gnt, wr_en, wr_sel, wr_data.
- Eligible set: elig = req & ~gnt & {N_REQ{~stall}}. The requester currently holding gnt is masked, so a req still high in the cycle it sees gnt does not cause a second write.
- Winner: first set bit of elig scanning ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1 (mod N_REQ).
- Winner w exists: at the next edge gnt <= onehot(w), wr_en <= 1, wr_sel <= addr of w, wr_data <= data of w, ptr <= (w+1) mod N_REQ.
- No winner: gnt <= 0, wr_en <= 0, wr_sel and wr_data hold their previous values, ptr unchanged.
- Requester protocol: assert req with address and data stable; keep them stable until gnt[i] is seen high. A new request may be presented the cycle after gnt[i] is seen; it is eligible once gnt[i] drops.
- Same-address writes from different requesters are not merged. Each is written in grant order, and the last one written wins.
- Exactly 0 or 1 gnt bit is set at any time; wr_en == |gnt always.

## Timing
- Reset (reset=0, asynchronous): gnt=0, wr_en=0, wr_sel=0, wr_data=0, ptr=0, within the same cycle and independent of clk.
- Reset asserted mid-operation: an in-flight write (wr_en=1) is dropped immediately. The granted requester may not have observed its gnt and re-arbitrates after release. Requesters still holding req are arbitrated normally from ptr=0 on the first edge after reset releases.
- Latency: req sampled at edge k → gnt, wr_en, wr_sel, wr_data valid during cycle k..k+1 → register file captures at edge k+1.
- Throughput: one write per cycle when two or more requesters are active. A single requester alone gets at most one write every 2 cycles because of the gnt mask.
- Fairness: with all N_REQ requesting continuously, every requester is granted exactly once in any N_REQ consecutive grants.
- stall=1 at edge k: no grant at edge k, ptr is frozen, and pending requests keep waiting. An already-registered write in the current cycle still completes.
- ptr wraps from N_REQ-1 to 0.

## Test plan
- Reset: hold reset=0 with req=4'b1111 and apply clocks → gnt=0, wr_en=0, wr_sel=0, wr_data=0 throughout. After release, the first grant is gnt=4'b0001.
- Single requester: req[2]=1, addr=4'hA, data=64'h1234 → one cycle later gnt=4'b0100, wr_en=1, wr_sel=4'hA, wr_data=64'h1234. req held → next cycle wr_en=0 (masked), then re-granted.
- Round-robin: req=4'b1111 held for 8 cycles from reset → gnt sequence 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000; wr_en=1 every cycle.
- Wrap and skip: ptr=3 with req=4'b0101 → gnt=4'b0001, then 4'b0100; ptr ends at 3.
- Stall: req=4'b0011 with stall=1 for 3 cycles → gnt=0, wr_en=0, ptr unchanged. stall=0 → gnt=4'b0001, next cycle 4'b0010.
- Mid-op reset: pulse reset low while wr_en=1 → all outputs 0 in the same cycle and ptr=0. After release with req=4'b1000 → gnt=4'b1000, wr_sel = that requester's address.
